// File: rtl/lut_seq_eval.sv
// rtl/lut_seq_eval.sv - serially reloadable LUT evaluator with a glitch-filtered registered output
// Shadow table is filled bit-serially and committed to the active table one cycle after the last bit.
module lut_seq_eval #(
  parameter int                 N_IN       = 3,
  parameter logic [2**N_IN-1:0] TBL_INIT   = '0,
  parameter int                 STABLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  output logic            out,
  output logic            out_valid
);
  localparam int DEPTH = 2**N_IN;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int RW    = $clog2(STABLE_CYC + 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state;
  logic [DEPTH-1:0] act;
  logic [DEPTH-1:0] shd;
  logic [CW-1:0]    bit_cnt;
  logic [RW-1:0]    run;
  logic [RW-1:0]    run_nxt;
  logic             prev_raw;
  logic             raw;
  logic             xfer;

  assign xfer = cfg_valid && cfg_ready;
  assign raw  = act[in_vec];

  // cfg_done marks the commit cycle; act only takes shd at the end of it, so a
  // same-cycle evaluation still sees the old table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      act       <= TBL_INIT;
      shd       <= '0;
      bit_cnt   <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (cfg_done) begin
        act <= shd;
      end
      if (xfer) begin
        shd <= {shd[DEPTH-2:0], cfg_bit};
      end
      if (cfg_start) begin
        state     <= LOAD;
        cfg_ready <= 1'b1;
        bit_cnt   <= '0;
      end else if (state == LOAD && xfer) begin
        bit_cnt <= bit_cnt + CW'(1);
        if (bit_cnt == CW'(DEPTH - 1)) begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
          cfg_done  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    run_nxt = RW'(1);
    if (raw == prev_raw) begin
      run_nxt = (run == RW'(STABLE_CYC)) ? run : run + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_raw  <= 1'b0;
      run       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        prev_raw <= raw;
        run      <= run_nxt;
        if (run_nxt == RW'(STABLE_CYC)) begin
          out <= raw;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_seq_eval.sv
// tb/tb_lut_seq_eval.sv - randomized self-checking bench for lut_seq_eval
// dut_a (S=1) and dut_b (S=3) share all stimulus; dut_c is the 4-input instance.
module tb_lut_seq_eval;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, c_in_valid = 1'b0;
  logic [3:0] in_vec = '0;
  logic cfg_start = 1'b0, c_cfg_start = 1'b0;
  logic cfg_valid = 1'b0, c_cfg_valid = 1'b0;
  logic cfg_bit = 1'b0;
  logic a_cfg_ready, a_cfg_done, a_out, a_out_valid;
  logic b_cfg_ready, b_cfg_done, b_out, b_out_valid;
  logic c_cfg_ready, c_cfg_done, c_out, c_out_valid;

  int vectors = 0, miscompares = 0;
  int done_a = 0, done_b = 0, done_c = 0, ovb = 0;

  localparam logic [7:0]  A_INIT = 8'hA5;
  localparam logic [7:0]  B_INIT = 8'h00;
  localparam logic [15:0] C_INIT = 16'h1234;

  logic [7:0]  a_tbl, b_tbl;
  logic [15:0] c_tbl;
  logic        a_mout, b_mout;
  logic        b_hist[$];

  lut_seq_eval #(.N_IN(3), .TBL_INIT(A_INIT), .STABLE_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec(in_vec[2:0]),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(a_cfg_ready), .cfg_done(a_cfg_done), .out(a_out), .out_valid(a_out_valid));

  lut_seq_eval #(.N_IN(3), .TBL_INIT(B_INIT), .STABLE_CYC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec(in_vec[2:0]),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(b_cfg_ready), .cfg_done(b_cfg_done), .out(b_out), .out_valid(b_out_valid));

  lut_seq_eval #(.N_IN(4), .TBL_INIT(C_INIT), .STABLE_CYC(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_vec(in_vec),
    .cfg_start(c_cfg_start), .cfg_valid(c_cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(c_cfg_ready), .cfg_done(c_cfg_done), .out(c_out), .out_valid(c_out_valid));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_cfg_done) done_a++;
    if (b_cfg_done) done_b++;
    if (c_cfg_done) done_c++;
    if (b_out_valid) ovb++;
  end

  // Reference: out takes raw once the trailing run of identical raws since reset reaches S.
  task automatic model_ab(input logic [2:0] v, output logic ea, output logic eb);
    logic r;
    int k;
    a_mout = a_tbl[v];
    r = b_tbl[v];
    b_hist.push_back(r);
    if (b_hist.size() > 3) void'(b_hist.pop_front());
    k = 0;
    for (int i = b_hist.size() - 1; i >= 0; i--) begin
      if (b_hist[i] != r) break;
      k++;
    end
    if (k >= 3) b_mout = r;
    ea = a_mout;
    eb = b_mout;
  endtask

  task automatic model_reset();
    a_tbl = A_INIT; b_tbl = B_INIT; c_tbl = C_INIT;
    a_mout = 1'b0; b_mout = 1'b0;
    b_hist.delete();
  endtask

  task automatic eval_ab(input logic [2:0] v);
    logic ea, eb;
    in_vec = {1'b0, v};
    in_valid = 1'b1;
    model_ab(v, ea, eb);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if ({a_out_valid, a_out, b_out_valid, b_out} !== {1'b1, ea, 1'b1, eb}) begin
      $display("FAIL eval vec=%0d got a_ov/a/b_ov/b=%b%b%b%b expected 1%b1%b",
               v, a_out_valid, a_out, b_out_valid, b_out, ea, eb);
      miscompares++;
    end
  endtask

  task automatic load(input bit on_c, input int n, input logic [15:0] bits,
                      input bit gaps, input bit ev, input bit exp_done);
    logic rdy, ea, eb;
    logic [2:0] v;
    if (on_c) c_cfg_start = 1'b1; else cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; c_cfg_start = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps && $urandom_range(1, 0) == 1) @(negedge clk);
      rdy = on_c ? c_cfg_ready : (a_cfg_ready & b_cfg_ready);
      vectors++;
      if (rdy !== 1'b1) begin
        $display("FAIL cfg_ready bit=%0d got %b expected 1", i, rdy);
        miscompares++;
      end
      cfg_bit = bits[i];
      if (on_c) c_cfg_valid = 1'b1; else cfg_valid = 1'b1;
      if (ev) begin
        v = 3'($urandom_range(7, 0));
        in_vec = {1'b0, v};
        in_valid = 1'b1;
        model_ab(v, ea, eb);
      end
      @(negedge clk);
      cfg_valid = 1'b0; c_cfg_valid = 1'b0;
      if (ev) begin
        in_valid = 1'b0;
        vectors++;
        if ({a_out, b_out, a_out_valid} !== {ea, eb, 1'b1}) begin
          $display("FAIL eval_during_load got a/b/ov=%b%b%b expected %b%b1", a_out, b_out, a_out_valid, ea, eb);
          miscompares++;
        end
      end
    end
    if (exp_done) begin
      rdy = on_c ? {c_cfg_done, c_cfg_ready} == 2'b10 : {a_cfg_done, b_cfg_done, a_cfg_ready} == 3'b110;
      vectors++;
      if (rdy !== 1'b1) begin
        $display("FAIL cfg_done_pulse got done=%b ready=%b expected done=1 ready=0",
                 on_c ? c_cfg_done : a_cfg_done, on_c ? c_cfg_ready : a_cfg_ready);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({a_cfg_ready, a_cfg_done, a_out, a_out_valid, b_cfg_ready, b_out, c_cfg_ready, c_out_valid} !== 8'b0) begin
      $display("FAIL reset_outputs got %b expected 00000000",
               {a_cfg_ready, a_cfg_done, a_out, a_out_valid, b_cfg_ready, b_out, c_cfg_ready, c_out_valid});
      miscompares++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int v = 0; v < 8; v++) eval_ab(3'(v));
  endtask

  task automatic test_reload();
    int sa = done_a, sb = done_b;
    logic [3:0] got;
    logic [2:0] vecs[4] = '{3'd7, 3'd6, 3'd2, 3'd0};
    load(1'b0, 8, 16'b1100_0100, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a_tbl = 8'hC4; b_tbl = 8'hC4;
    #1;
    vectors++;
    if (done_a - sa !== 1 || done_b - sb !== 1) begin
      $display("FAIL reload_done_count got %0d/%0d expected 1/1", done_a - sa, done_b - sb);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      eval_ab(vecs[i]);
      got[3-i] = a_out;
    end
    vectors++;
    if (got !== 4'b1110) begin
      $display("FAIL reload_outputs got %b expected 1110", got);
      miscompares++;
    end
  endtask

  task automatic test_glitch();
    int so;
    logic [5:0] got;
    logic [2:0] seq[6] = '{3'd2, 3'd2, 3'd0, 3'd2, 3'd2, 3'd2};
    repeat (3) eval_ab(3'd0);
    @(negedge clk);
    #1 so = ovb;
    for (int i = 0; i < 6; i++) begin
      eval_ab(seq[i]);
      got[5-i] = b_out;
    end
    vectors++;
    if (got !== 6'b000001) begin
      $display("FAIL glitch_filter got %b expected 000001", got);
      miscompares++;
    end
    @(negedge clk);
    #1;
    vectors++;
    if (ovb - so !== 6 || b_out_valid !== 1'b0) begin
      $display("FAIL glitch_out_valid_pulses got %0d (ov=%b) expected 6 (ov=0)", ovb - so, b_out_valid);
      miscompares++;
    end
  endtask

  task automatic test_collision();
    logic [7:0] nt;
    logic [2:0] v, w;
    nt = 8'($urandom);
    v = 3'($urandom_range(7, 0));
    w = 3'($urandom_range(7, 0));
    nt[v] = ~a_tbl[v];
    nt[w] = ~a_tbl[w];
    load(1'b0, 8, {8'h00, nt}, 1'b0, 1'b0, 1'b1);
    eval_ab(v);
    a_tbl = nt; b_tbl = nt;
    eval_ab(w);
  endtask

  task automatic test_reset_midload();
    int sa;
    logic [7:0] nt;
    sa = done_a;
    load(1'b0, 4, 16'($urandom), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({a_cfg_ready, b_cfg_ready, a_out, a_out_valid} !== 4'b0) begin
      $display("FAIL reset_midload_outputs got %b expected 0000", {a_cfg_ready, b_cfg_ready, a_out, a_out_valid});
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (done_a !== sa) begin
      $display("FAIL reset_midload_no_done got %0d expected %0d", done_a, sa);
      miscompares++;
    end
    for (int v = 0; v < 8; v++) eval_ab(3'(v));
    nt = 8'($urandom);
    load(1'b0, 8, {8'h00, nt}, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a_tbl = nt; b_tbl = nt;
    for (int v = 0; v < 8; v++) eval_ab(3'(v));
  endtask

  task automatic test_restart();
    int sa;
    logic [7:0] nt;
    sa = done_a;
    nt = 8'($urandom);
    load(1'b0, 5, 16'($urandom), 1'b0, 1'b0, 1'b0);
    load(1'b0, 8, {8'h00, nt}, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    a_tbl = nt; b_tbl = nt;
    #1;
    vectors++;
    if (done_a - sa !== 1) begin
      $display("FAIL restart_done_count got %0d expected 1", done_a - sa);
      miscompares++;
    end
    for (int v = 0; v < 8; v++) eval_ab(3'(v));
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(3, 0) == 0) @(negedge clk);
      eval_ab(3'($urandom_range(7, 0)));
    end
  endtask

  task automatic test_exhaust();
    logic [15:0] t;
    for (int k = 0; k < 3; k++) begin
      t = 16'($urandom);
      load(1'b1, 16, t, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      c_tbl = t;
      for (int v = 0; v < 16; v++) begin
        in_vec = 4'(v);
        c_in_valid = 1'b1;
        @(negedge clk);
        c_in_valid = 1'b0;
        vectors++;
        if ({c_out_valid, c_out} !== {1'b1, c_tbl[v]}) begin
          $display("FAIL exhaust tbl=%h vec=%0d got ov/out=%b%b expected 1%b", t, v, c_out_valid, c_out, c_tbl[v]);
          miscompares++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reload();
    test_glitch();
    test_collision();
    test_reset_midload();
    test_restart();
    test_random();
    test_exhaust();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
